// File: rtl/add.sv
// Registered WIDTH-bit ripple-carry adder with carry-in/carry-out, 1-cycle latency.
// Define ADD_OVERFLOW_EN to add the registered signed-overflow output ov.

module add_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
`ifdef ADD_OVERFLOW_EN
  output logic             co,
  output logic             ov
`else
  output logic             co
`endif
);
  localparam int STAGES = 1;

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             vld_q;
  logic [STAGES:0]  vld_pipe;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    add_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_pipe[0];
  end

  // Result registers hold across idle cycles; only a valid beat updates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      y  <= '0;
      co <= 1'b0;
    end else if (in_valid) begin
      y  <= s;
      co <= c[WIDTH];
    end
  end

`ifdef ADD_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst)           ov <= 1'b0;
    else if (in_valid) ov <= c[WIDTH-1] ^ c[WIDTH];
  end
`endif

endmodule

// File: tb/tb_add.sv
// Scoreboard bench for add: drives WIDTH=8, 1 and 16 instances in lockstep
// with directed steps followed by random traffic with idle gaps.

module tb_add;
  logic        clk = 1'b0;
  logic        rst, in_valid, ci;
  logic [7:0]  a8, b8, y8;
  logic [0:0]  a1, b1, y1;
  logic [15:0] a16, b16, y16;
  logic        co8, co1, co16, ov8, ov1, ov16;
  logic        vld8, vld1, vld16;

  int checks = 0;
  int failures = 0;

  logic [53:0] sbq [$];
  logic [53:0] hold;
  logic [17:0] obs [3];
  logic        ovld [3];

  always #5 clk = ~clk;

  add #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .ci(ci),
`ifdef ADD_OVERFLOW_EN
    .ov(ov8),
`endif
    .out_valid(vld8), .y(y8), .co(co8));

  add #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .ci(ci),
`ifdef ADD_OVERFLOW_EN
    .ov(ov1),
`endif
    .out_valid(vld1), .y(y1), .co(co1));

  add #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .ci(ci),
`ifdef ADD_OVERFLOW_EN
    .ov(ov16),
`endif
    .out_valid(vld16), .y(y16), .co(co16));

`ifndef ADD_OVERFLOW_EN
  assign ov8  = 1'b0;
  assign ov1  = 1'b0;
  assign ov16 = 1'b0;
`endif

  assign obs[0]  = {ov8,  co8,  8'h00, y8};
  assign obs[1]  = {ov1,  co1,  15'h0000, y1};
  assign obs[2]  = {ov16, co16, y16};
  assign ovld[0] = vld8;
  assign ovld[1] = vld1;
  assign ovld[2] = vld16;

  // Returns {ov, co, y zero-extended to 16 bits} for a w-bit adder.
  function automatic logic [17:0] model(input int w, input logic [15:0] aa, bb, input logic c);
    logic [16:0] mask, full;
    logic [15:0] ys;
    logic        cout, ovf;
    mask = (17'd1 << w) - 17'd1;
    full = ({1'b0, aa} & mask) + ({1'b0, bb} & mask) + {16'd0, c};
    ys   = full[15:0] & mask[15:0];
    cout = full[w];
`ifdef ADD_OVERFLOW_EN
    ovf  = (aa[w-1] == bb[w-1]) && (ys[w-1] != aa[w-1]);
`else
    ovf  = 1'b0;
`endif
    return {ovf, cout, ys};
  endfunction

  task automatic chk(input string tag, input int d, input logic [17:0] o, e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, o, e);
    end
  endtask

  task automatic step(input logic r, v, input logic [15:0] aa, bb, input logic c);
    rst = r; in_valid = v; ci = c;
    a16 = aa; b16 = bb; a8 = aa[7:0]; b8 = bb[7:0]; a1 = aa[0]; b1 = bb[0];
    if (r) begin
      sbq.delete();
      hold = '0;
    end else if (v) begin
      sbq.push_back({model(16, aa, bb, c), model(1, aa, bb, c), model(8, aa, bb, c)});
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++)
      chk("out_valid", d, {17'd0, ovld[d]}, {17'd0, (!r && v)});
    if (!r && v) begin
      chk("sb_nonempty", 0, {17'd0, sbq.size() != 0}, 18'd1);
      if (sbq.size() != 0) hold = sbq.pop_front();
    end
    for (int d = 0; d < 3; d++)
      chk("result", d, obs[d], hold[d*18 +: 18]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ci = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    hold = '0;

    // reset wins over in_valid
    step(1'b1, 1'b1, 16'h00FE, 16'h0001, 1'b1);
    step(1'b1, 1'b1, 16'h00FE, 16'h0001, 1'b1);
    // near-overflow, back-to-back
    step(1'b0, 1'b1, 16'h00FE, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'h00FE, 16'h0001, 1'b1);
    // mid-range, signed overflow on the second beat
    step(1'b0, 1'b1, 16'h007E, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'h007E, 16'h0001, 1'b1);
    // MSB carry
    step(1'b0, 1'b1, 16'h0080, 16'h0080, 1'b0);
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
    // all-ones boundaries
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    // idle holds
    step(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    // unknown operands propagate, then hold through idle
    step(1'b0, 1'b1, 16'hxxxx, 16'hxxxx, 1'bx);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    // reset mid-stream discards the in-flight beat
    step(1'b1, 1'b1, 16'h00FF, 16'h00FF, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 1000; i++)
      step(1'b0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add.md
Name: add

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out.
- Computes {co, y} = a + b + ci and presents the result one clock after the operands are accepted.
- Used as the basic arithmetic primitive in the arith library. Larger datapaths cascade instances by chaining co into ci.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal values are 1 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a, b and ci are valid this cycle.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- ci  input  1  carry-in, weight 2^0.
- out_valid  output  1  y and co hold a new result.
- y  output  WIDTH  sum, registered.
- co  output  1  carry-out, the bit of weight 2^WIDTH; registered.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- All state changes on the rising edge of clk.
- Reset:
  - rst=1 at an edge sets y=0, co=0, out_valid=0.
  - rst has priority over in_valid.
  - Reset asserted mid-stream discards any in-flight result.
- Arithmetic:
  - full = a + b + ci, computed at WIDTH+1 bits.
  - y = full[WIDTH-1:0]; co = full[WIDTH].
  - Unsigned modular sum; no saturation.
- Structure:
  - Combinational ripple-carry chain of WIDTH full adders, built as a generate loop over a full-adder cell (sum = a^b^c, carry = ab|ac|bc).
  - Carry into bit 0 is ci.
  - Output registers follow the chain.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, then y, co and out_valid=1 are visible after edge N.
- Throughput: one operation per cycle; back-to-back in_valid is supported.
- Idle: in_valid=0 at an edge sets out_valid=0. y and co hold their previous values.
- No backpressure; the consumer must sample whenever out_valid=1.
- Boundary cases:
  - all-ones + 0 + 1 gives y=0, co=1.
  - all-ones + all-ones + 1 gives y=all-ones, co=1.
  - MSB-only + MSB-only gives y=0, co=1.
- Unknown inputs (simulation): X or Z on a, b or ci with in_valid=1 must propagate to y/co as X. No X-masking logic is permitted. out_valid is unaffected.

Optional Feature:
- Macro: ADD_OVERFLOW_EN.
- When defined:
  - Adds output port ov (1 bit, registered, same timing as co).
  - ov = carry into the MSB XOR carry out of the MSB, i.e. two's-complement signed overflow.
  - ov resets to 0 and holds when in_valid=0.
- When undefined: port ov does not exist and no extra logic is generated.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> y=00, co=0, out_valid=0. First in_valid after rst deasserts yields out_valid=1 one cycle later.
- Near-overflow, a=FE b=01:
  - ci=0 -> y=FF, co=0.
  - next cycle ci=1 -> y=00, co=1. Back-to-back, 1-cycle latency each.
- Mid-range, a=7E b=01:
  - ci=0 -> y=7F, co=0.
  - ci=1 -> y=80, co=0; ov=1 if ADD_OVERFLOW_EN.
- MSB carry: a=80 b=80 ci=0 -> y=00, co=1; ov=1 if ADD_OVERFLOW_EN.
- Unknown: a=xx b=xx ci=x, in_valid=1 -> y and co are X, out_valid=1. Then in_valid=0 -> out_valid=0 and y/co hold.
- Random: 1000 random a, b, ci with random in_valid gaps -> {co,y} equals a+b+ci one cycle later. Repeat with WIDTH=1 and WIDTH=16.
